// File: rtl/dec_2to4_pulse_if.sv
// Handshake bundle for dec_2to4_pulse.
//   dc_in    : binary code to decode (CW bits)
//   zrf      : zero flag, request carries no active line
//   in_valid : dc_in/zrf valid
//   in_ready : decoder can accept; transfer = in_valid & in_ready
//   dc_out   : one-hot decoded strobe (2**CW bits)
//   busy     : decoder not idle
//   done     : one-cycle marker at the end of each pulse phase
// master = request source / observer, slave = decoder.
interface dec_2to4_pulse_if #(
  parameter int CW = 2
);
  localparam int OW = 1 << CW;

  logic [CW-1:0] dc_in;
  logic          zrf;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] dc_out;
  logic          busy;
  logic          done;

  modport master (
    output dc_in, zrf, in_valid,
    input  in_ready, dc_out, busy, done
  );

  modport slave (
    input  dc_in, zrf, in_valid,
    output in_ready, dc_out, busy, done
  );
endinterface

// File: rtl/dec_2to4_pulse.sv
// Sequential 2**CW-line decoder producing timed one-hot strobes.
// A request (code + zero flag) is taken over a valid/ready handshake; the
// matching dc_out line is driven for PULSE_LEN cycles, followed by GAP forced
// idle cycles. A zero-flag request produces no strobe, only the done marker.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dec_2to4_pulse_if.slave (dc_in, zrf, in_valid -> in_ready,
//           dc_out, busy, done; all outputs registered)
//
// state   | meaning
// S_IDLE  | in_ready high, waiting for a transfer
// S_PULSE | decoded line high, counting PULSE_LEN cycles
// S_ZERO  | zero-flag request: single done cycle, dc_out stays 0
// S_GAP   | forced idle, counting GAP cycles
module dec_2to4_pulse #(
  parameter int CW        = 2,
  parameter int PULSE_LEN = 4,
  parameter int GAP       = 1
) (
  input logic             clk,
  input logic             rst_n,
  dec_2to4_pulse_if.slave bus
);

  localparam int OW   = 1 << CW;
  localparam int MAXC = (PULSE_LEN > GAP) ? PULSE_LEN : GAP;
  localparam int CNTW = $clog2(MAXC + 1);

  // Counter holds "cycles remaining in this state minus one".
  localparam logic [CNTW-1:0] PULSE_RLD = CNTW'(PULSE_LEN - 1);
  localparam logic [CNTW-1:0] GAP_RLD   = (GAP > 0) ? CNTW'(GAP - 1) : '0;
  localparam logic [OW-1:0]   ONE       = OW'(1);

  generate
    if (CW < 1 || CW > 4) begin : g_bad_cw
      $error("dec_2to4_pulse: CW must be in 1..4");
    end
    if (PULSE_LEN < 1) begin : g_bad_pulse
      $error("dec_2to4_pulse: PULSE_LEN must be >= 1");
    end
    if (GAP < 0) begin : g_bad_gap
      $error("dec_2to4_pulse: GAP must be >= 0");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_ZERO  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [OW-1:0]   dc_out_q, dc_out_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dc_out_q   <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dc_out_q   <= dc_out_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dc_out_d = dc_out_q;

    case (state_q)
      S_IDLE: begin
        // in_ready_q (not state) gates acceptance so nothing is taken on the
        // first edge after reset release.
        if (bus.in_valid && in_ready_q) begin
          if (bus.zrf) begin
            state_d  = S_ZERO;
            cnt_d    = '0;
            dc_out_d = '0;
          end else begin
            state_d  = S_PULSE;
            cnt_d    = PULSE_RLD;
            dc_out_d = ONE << bus.dc_in;
          end
        end
      end

      S_PULSE, S_ZERO: begin
        if (cnt_q == '0) begin
          dc_out_d = '0;
          if (GAP > 0) begin
            state_d = S_GAP;
            cnt_d   = GAP_RLD;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end

      S_GAP: begin
        dc_out_d = '0;
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end

      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        dc_out_d = '0;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_ZERO) ||
                 ((state_d == S_PULSE) && (cnt_d == '0));
  end

  assign bus.in_ready = in_ready_q;
  assign bus.dc_out   = dc_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
